cla_pipelined_adder: RTL and testbench
======================================

CLA_PIPELINED_ADDER -- requirements
Module: cla_pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 16: bits per pipeline stage; WIDTH multiple of SLICE, SLICE multiple of 4.
REQ-003 SHALL derive localparam NSTAGE = WIDTH/SLICE (default 2).
REQ-004 SHALL use one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry/borrow in
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- c_out  out  1  carry out of MSB
- ovf  out  1  signed overflow
- zero  out  1  sum == 0
- p  out  1  group propagate, whole word
- g  out  1  group generate, whole word

Function
REQ-005 SHALL compute sum, c_out = a + (sub ? ~b : b) + (c_in ^ sub); this gives a+b+c_in for add and a-b-c_in for subtract.
REQ-006 Stage k (0..NSTAGE-1) SHALL add slice k, using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-007 Unprocessed upper operand slices and finished lower sum slices SHALL be carried forward in skew registers alongside each stage.
REQ-008 SHALL use a global advance = !out_valid || out_ready; all stage registers and valid bits shift only when advance=1.
REQ-009 SHALL drive in_ready = advance (combinational); a beat is accepted when in_valid && in_ready.
REQ-010 Latency SHALL be NSTAGE cycles: a beat accepted at edge T appears with out_valid=1 after edge T+NSTAGE-1, provided no stall.
REQ-011 Bubbles SHALL propagate; the pipeline does not compress them.
REQ-012 While out_valid && !out_ready, sum, c_out, ovf, zero, p and g SHALL remain stable.
REQ-013 Results SHALL leave in acceptance order with no loss or duplication.
REQ-014 ovf SHALL equal (carry into MSB) XOR c_out.
REQ-015 zero SHALL be 1 iff all WIDTH sum bits are 0.
REQ-016 p SHALL equal the AND of all a_i ^ b'_i, where b' is the operand after the sub inversion.
REQ-017 g SHALL be the whole-word group generate of a and b', independent of carry-in; per-slice P/G SHALL be combined across stages.
REQ-018 If a beat is accepted on the same edge a result is consumed, both SHALL happen.
REQ-019 Inputs SHALL be ignored when in_valid=0.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear all valid bits, carries and data registers.
REQ-021 During reset: out_valid=0, sum=0, c_out=ovf=p=g=0, zero=0.
REQ-022 Reset mid-operation SHALL discard in-flight beats; none emerge after reset release.
REQ-023 in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-024 Package cla_pkg SHALL hold the default WIDTH/SLICE constants and the ADD=0/SUB=1 op encoding.
REQ-025 SHALL instantiate sub-module cla_slice per stage: a combinational SLICE-bit CLA built from 4-bit lookahead groups and a second-level LCU, with outputs sum, c_out, c_msb, p, g.
REQ-026 No combinational path SHALL run from a/b to any output; in_ready SHALL depend only on out_valid and out_ready.

Verification
REQ-027 Add 0xFFFFFFFF + 0x00000001, c_in=0 -> after 2 cycles sum=0, c_out=1, zero=1, ovf=0, p=0, g=1.
REQ-028 sub=1, 0x00000005 - 0x00000007, c_in=0 -> sum=0xFFFFFFFE, c_out=0, ovf=0, zero=0.
REQ-029 Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, c_out=0; add 0x0000FFFF + 0x00000001 -> sum=0x00010000 (carry crosses the stage boundary).
REQ-030 Send 4 back-to-back beats, hold out_ready=0 for 3 cycles after the first out_valid -> outputs held, in_ready=0 during the stall, all 4 results emerge in order.
REQ-031 Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
REQ-032 WIDTH=64, SLICE=16: 0xFFFFFFFFFFFFFFFF + 1 -> sum=0, c_out=1, latency 4 cycles.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
// Default geometry, lookahead group size and the add/subtract op encoding.
package cla_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 16;
    localparam int GRP       = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder slice.
// 4-bit lookahead groups joined by a second-level carry unit.
module cla_slice
    import cla_pkg::*;
#(
    parameter int W = DEF_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb,
    output logic         p,
    output logic         g
);

    localparam int NG = W / GRP;

    logic [W-1:0]  bp;
    logic [W-1:0]  bg;
    logic [W-1:0]  cb;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic          gacc;

    always_comb begin
        bp   = a ^ b;
        bg   = a & b;
        gp   = '0;
        gg   = '0;
        gc   = '0;
        cb   = '0;
        gacc = 1'b0;
        for (int i = 0; i < NG; i++) begin
            gp[i] = &bp[i*GRP +: GRP];
            gg[i] = bg[i*GRP+3]
                  | (bp[i*GRP+3] & bg[i*GRP+2])
                  | (bp[i*GRP+3] & bp[i*GRP+2] & bg[i*GRP+1])
                  | (bp[i*GRP+3] & bp[i*GRP+2] & bp[i*GRP+1] & bg[i*GRP]);
        end
        // second-level unit: group carries, plus a carry-in-free generate
        gc[0] = c_in;
        for (int i = 0; i < NG; i++) begin
            gc[i+1] = gg[i] | (gp[i] & gc[i]);
            gacc    = gg[i] | (gp[i] & gacc);
        end
        for (int i = 0; i < NG; i++) begin
            cb[i*GRP]   = gc[i];
            cb[i*GRP+1] = bg[i*GRP] | (bp[i*GRP] & gc[i]);
            cb[i*GRP+2] = bg[i*GRP+1]
                        | (bp[i*GRP+1] & bg[i*GRP])
                        | (bp[i*GRP+1] & bp[i*GRP] & gc[i]);
            cb[i*GRP+3] = bg[i*GRP+2]
                        | (bp[i*GRP+2] & bg[i*GRP+1])
                        | (bp[i*GRP+2] & bp[i*GRP+1] & bg[i*GRP])
                        | (bp[i*GRP+2] & bp[i*GRP+1] & bp[i*GRP] & gc[i]);
        end
        sum   = bp ^ cb;
        c_out = gc[NG];
        c_msb = cb[W-1];
        p     = &gp;
        g     = gacc;
    end

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined add/subtract: one CLA slice per stage, skewed operands and sums.
// Single global advance with valid/ready handshake on both ends.
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             p,
    output logic             g
);

    localparam int NSTAGE = WIDTH / SLICE;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = (op_e'(sub) == OP_SUB) ? ~b : b;
    assign c_eff    = c_in ^ sub;

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        localparam int IW = WIDTH - k*SLICE;
        localparam int OW = (k+1)*SLICE;

        logic             v_i, c_i, p_i, g_i, z_i;
        logic [IW-1:0]    a_i, b_i;
        logic [SLICE-1:0] sl_sum;
        logic             sl_co, sl_cm, sl_p, sl_g;
        logic [OW-1:0]    s_nx;
        logic             v_q, c_q, p_q, g_q, z_q;
        logic [OW-1:0]    s_q;

        if (k == 0) begin : head
            assign v_i  = in_valid;
            assign a_i  = a;
            assign b_i  = b_eff;
            assign c_i  = c_eff;
            assign p_i  = 1'b1;
            assign g_i  = 1'b0;
            assign z_i  = 1'b1;
            assign s_nx = sl_sum;
        end else begin : body
            assign v_i  = stg[k-1].v_q;
            assign a_i  = stg[k-1].mid.a_q;
            assign b_i  = stg[k-1].mid.b_q;
            assign c_i  = stg[k-1].c_q;
            assign p_i  = stg[k-1].p_q;
            assign g_i  = stg[k-1].g_q;
            assign z_i  = stg[k-1].z_q;
            assign s_nx = {sl_sum, stg[k-1].s_q};
        end

        cla_slice #(.W(SLICE)) u_slice (
            .a     (a_i[SLICE-1:0]),
            .b     (b_i[SLICE-1:0]),
            .c_in  (c_i),
            .sum   (sl_sum),
            .c_out (sl_co),
            .c_msb (sl_cm),
            .p     (sl_p),
            .g     (sl_g)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                p_q <= 1'b0;
                g_q <= 1'b0;
                z_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_i;
                if (v_i) begin
                    s_q <= s_nx;
                    c_q <= sl_co;
                    p_q <= p_i & sl_p;
                    g_q <= sl_g | (sl_p & g_i);
                    z_q <= z_i & (sl_sum == '0);
                end
            end
        end

        if (k == NSTAGE-1) begin : last
            logic ovf_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (advance && v_i)
                    ovf_q <= sl_cm ^ sl_co;
            end
        end else begin : mid
            // upper operand slices still waiting for their stage
            logic [IW-SLICE-1:0] a_q, b_q;
            logic                unused_cm;
            assign unused_cm = sl_cm;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance && v_i) begin
                    a_q <= a_i[IW-1:SLICE];
                    b_q <= b_i[IW-1:SLICE];
                end
            end
        end
    end

    assign out_valid = stg[NSTAGE-1].v_q;
    assign sum       = stg[NSTAGE-1].s_q;
    assign c_out     = stg[NSTAGE-1].c_q;
    assign ovf       = stg[NSTAGE-1].last.ovf_q;
    assign zero      = stg[NSTAGE-1].z_q;
    assign p         = stg[NSTAGE-1].p_q;
    assign g         = stg[NSTAGE-1].g_q;

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Scoreboard bench for cla_pipelined_adder (32-bit main, 64-bit latency).
// Expected results come from a plain arithmetic model of each accepted beat.
module tb_cla_pipelined_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic [4:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, c_in, sub;
    logic [31:0] a, b, sum;
    logic        out_valid, out_ready, c_out, ovf, zero, p, g;

    logic        iv_w, ir_w, ov_w, co_w, ovf_w, z_w, p_w, g_w;
    logic [63:0] a_w, b_w, s_w;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic rnd_rdy = 1'b0;
    logic held = 1'b0;
    logic [36:0] hdata = '0;

    always #5 clk = ~clk;

    cla_pipelined_adder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf),
        .zero(zero), .p(p), .g(g)
    );

    cla_pipelined_adder #(.WIDTH(64), .SLICE(16)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv_w), .in_ready(ir_w),
        .a(a_w), .b(b_w), .c_in(1'b0), .sub(1'b0),
        .out_valid(ov_w), .out_ready(1'b1),
        .sum(s_w), .c_out(co_w), .ovf(ovf_w),
        .zero(z_w), .p(p_w), .g(g_w)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] av, bv,
                                   input logic ci, sv);
        logic [31:0] bb;
        logic        ce;
        logic [32:0] full, raw;
        logic [31:0] lo;
        exp_t        m;
        bb   = sv ? ~bv : bv;
        ce   = ci ^ sv;
        full = {1'b0, av} + {1'b0, bb} + {32'd0, ce};
        raw  = {1'b0, av} + {1'b0, bb};
        lo   = {1'b0, av[30:0]} + {1'b0, bb[30:0]} + {31'd0, ce};
        m.sum   = full[31:0];
        m.flags = {full[32], lo[31] ^ full[32], full[31:0] == 32'd0,
                   &(av ^ bb), raw[32]};
        return m;
    endfunction

    always @(posedge clk)
        if (rst_n && in_valid && in_ready)
            sb.push_back(model(a, b, c_in, sub));

    always @(posedge clk)
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({sum, c_out, ovf, zero, p, g}),
                      64'(hdata));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("flags", 64'({c_out, ovf, zero, p, g}),
                          64'(e.flags));
                end
            end
            held  = out_valid && !out_ready;
            hdata = {sum, c_out, ovf, zero, p, g};
        end
    end

    task automatic send(input logic [31:0] av, bv, input logic ci, sv);
        a = av; b = bv; c_in = ci; sub = sv;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() > 0; n++)
            @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        iv_w = 1'b0; a_w = '0; b_w = '0;
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", 64'({c_out, ovf, zero, p, g}), 64'd0);
        check("rst_valid64", 64'(ov_w), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("lat_edge0", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge1", 64'(out_valid), 64'd1);
        check("wrap_sum", 64'(sum), 64'd0);
        check("wrap_flags", 64'({c_out, ovf, zero, p, g}), 64'b10101);
        drain();

        send(32'h5, 32'h7, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h0, 32'h0, 1'b1, 1'b0);
        send(32'h0, 32'h0, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        send(32'h5, 32'h5, 1'b0, 1'b1);
        send(32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send($urandom, (i % 7 == 0) ? ~a : $urandom,
                 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain();
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b0;

        fork
            begin
                send(32'h10, 32'h1, 1'b0, 1'b0);
                send(32'h20, 32'h2, 1'b0, 1'b1);
                send(32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
                send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 20 && !out_valid; k++)
                    @(negedge clk);
                check("stall_vis", 64'(out_valid), 64'd1);
                check("stall_rdy", 64'(in_ready), 64'd0);
                repeat (2) begin
                    @(negedge clk);
                    check("stall_rdy", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h1, 32'h2, 1'b0, 1'b0);
        send(32'h3, 32'h4, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale", 64'(seen), 64'd0);

        @(posedge clk);
        #1;
        a_w = '1; b_w = 64'd1; iv_w = 1'b1;
        check("ready64", 64'(ir_w), 64'd1);
        @(posedge clk);
        #1 iv_w = 1'b0;
        n = 1;
        while (!ov_w && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("lat64", 64'(n), 64'd4);
        check("sum64", s_w, 64'd0);
        check("co64", 64'({co_w, z_w}), 64'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
